// File: rtl/alu_core.sv
// alu_core: small sequenced ALU with one-hot operand/op select.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   on         enable; requests accepted only while high, dropping it in EXEC aborts
//   in_sel     one-hot operand source: 100 persist (A<=out), 010 load (A<=num1), 001 clear
//   num1/num2  operand A / operand B sources
//   out_sel    one-hot op: [6]ADD [5]SUB [4]AND [3]OR [2]XOR [1]SHL [0]MUL
//   out        registered result
//   carry      ADD carry-out / SUB borrow
//   zero       newly written out == 0
//   ovf        MUL high product half nonzero
//   busy/done/err  state decodes (EXEC / DONE / ERR), registered
//   currState  registered state, nextState combinational next state
//
// state | meaning
// IDLE  | waiting for a request; clear handled here
// EXEC  | operation running (1 cycle, or WIDTH cycles for MUL)
// DONE  | one-cycle completion pulse, result already in out
// ERR   | one-cycle pulse for a non-one-hot op select
module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [6:0]       out_sel,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [6:0]         op;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   shamt;
  logic [WIDTH-1:0]   res;
  logic               res_carry;
  logic               res_ovf;
  logic               req_persist;
  logic               req_load;
  logic               req_clear;
  logic               op_valid;
  logic               exec_last;
  logic [WIDTH-1:0]   a_src;

  assign currState = state;
  assign nextState = state_nx;

  assign req_persist = (in_sel == 3'b100);
  assign req_load    = (in_sel == 3'b010);
  assign req_clear   = (in_sel == 3'b001);
  assign op_valid    = (out_sel != 7'd0) && ((out_sel & (out_sel - 7'd1)) == 7'd0);
  assign a_src       = req_persist ? out : num1;
  // Non-MUL ops finish after one EXEC cycle; MUL runs until the down-counter hits zero.
  assign exec_last   = !op[0] || (cnt == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (on && (req_load || req_persist))
          state_nx = op_valid ? EXEC : ERR;
      end
      EXEC: begin
        if (!on)
          state_nx = IDLE;
        else if (exec_last)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    shamt     = b % WIDTH_V;
    // b is shifted right each MUL step, so b[0] is the current multiplier bit.
    prod_step = b[0] ? (prod + mcand) : prod;
    res       = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    if (op[6]) begin
      res       = sum_ext[WIDTH-1:0];
      res_carry = sum_ext[WIDTH];
    end else if (op[5]) begin
      res       = a - b;
      res_carry = (a < b);
    end else if (op[4]) begin
      res = a & b;
    end else if (op[3]) begin
      res = a | b;
    end else if (op[2]) begin
      res = a ^ b;
    end else if (op[1]) begin
      res = a << shamt;
    end else if (op[0]) begin
      res     = prod_step[WIDTH-1:0];
      res_ovf = |prod_step[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      out   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == EXEC);
      done  <= (state_nx == DONE);
      err   <= (state_nx == ERR);
      case (state)
        IDLE: begin
          if (on) begin
            if (req_clear) begin
              a     <= '0;
              b     <= '0;
              out   <= '0;
              carry <= 1'b0;
              zero  <= 1'b0;
              ovf   <= 1'b0;
            end else if ((req_load || req_persist) && op_valid) begin
              a     <= a_src;
              b     <= num2;
              op    <= out_sel;
              cnt   <= CNT_LOAD;
              prod  <= '0;
              mcand <= {{WIDTH{1'b0}}, a_src};
            end
          end
        end
        EXEC: begin
          if (on) begin
            if (op[0]) begin
              prod  <= prod_step;
              mcand <= mcand << 1;
              b     <= b >> 1;
              cnt   <= cnt - CW'(1);
            end
            if (exec_last) begin
              out   <= res;
              carry <= res_carry;
              zero  <= (res == '0);
              ovf   <= res_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  localparam int W   = 8;
  localparam int MOD = 256;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_AND = 7'b0010000;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_XOR = 7'b0000100;
  localparam logic [6:0] OP_SHL = 7'b0000010;
  localparam logic [6:0] OP_MUL = 7'b0000001;

  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_CLEAR   = 3'b001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         on = 1'b0;
  logic [2:0]   in_sel = 3'b000;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic [6:0]   out_sel = 7'd0;
  logic [W-1:0] out;
  logic         carry, zero, ovf, busy, done, err;
  logic [1:0]   currState, nextState;

  alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .out(out), .carry(carry), .zero(zero), .ovf(ovf),
    .busy(busy), .done(done), .err(err), .currState(currState), .nextState(nextState)
  );

  always #5 clk = ~clk;

  // Reference model: architectural result/flags plus the expected state per cycle.
  logic [W-1:0] m_out = '0;
  logic         m_carry = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;
  logic [1:0]   exp_state = S_IDLE;
  logic         exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic         chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(currState), int'(exp_state));
      chk("busy",  int'(busy),      int'(exp_busy));
      chk("done",  int'(done),      int'(exp_done));
      chk("err",   int'(err),       int'(exp_err));
      chk("out",   int'(out),       int'(m_out));
      chk("carry", int'(carry),     int'(m_carry));
      chk("zero",  int'(zero),      int'(m_zero));
      chk("ovf",   int'(ovf),       int'(m_ovf));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [2:0] isel, input int n1, input int n2, input logic [6:0] osel);
    int a_i, b_i, r, nexec;
    a_i = (isel == IN_PERSIST) ? int'(m_out) : n1;
    b_i = n2;
    on = 1'b1; in_sel = isel; num1 = W'(n1); num2 = W'(n2); out_sel = osel;
    #1 chk("next_state_req", int'(nextState), ($countones(osel) == 1) ? int'(S_EXEC) : int'(S_ERR));
    next_cycle();
    if ($countones(osel) != 1) begin
      exp_state = S_ERR; exp_err = 1'b1;
      next_cycle();
      exp_state = S_IDLE; exp_err = 1'b0; on = 1'b0;
      return;
    end
    exp_state = S_EXEC; exp_busy = 1'b1;
    nexec = osel[0] ? W : 1;
    repeat (nexec - 1) next_cycle();
    next_cycle();
    r = 0; m_carry = 1'b0; m_ovf = 1'b0;
    if (osel[6]) begin
      r = a_i + b_i; m_carry = (r >= MOD);
    end else if (osel[5]) begin
      r = a_i - b_i + MOD; m_carry = (a_i < b_i);
    end else if (osel[4]) r = a_i & b_i;
    else if (osel[3]) r = a_i | b_i;
    else if (osel[2]) r = a_i ^ b_i;
    else if (osel[1]) r = a_i << (b_i % W);
    else begin
      r = a_i * b_i; m_ovf = ((r / MOD) != 0);
    end
    m_out  = W'(r % MOD);
    m_zero = ((r % MOD) == 0);
    exp_busy = 1'b0; exp_state = S_DONE; exp_done = 1'b1;
    next_cycle();
    exp_done = 1'b0; exp_state = S_IDLE; on = 1'b0;
  endtask

  task automatic start_mul(input int n1, input int n2, input int k);
    on = 1'b1; in_sel = IN_LOAD; num1 = W'(n1); num2 = W'(n2); out_sel = OP_MUL;
    next_cycle();
    exp_state = S_EXEC; exp_busy = 1'b1;
    repeat (k - 1) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out",   int'(out),       0);
    chk("reset_state", int'(currState), int'(S_IDLE));
    chk("reset_busy",  int'(busy),      0);
    chk("reset_done",  int'(done),      0);
    chk("reset_err",   int'(err),       0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Enable low: a valid request is ignored.
    in_sel = IN_LOAD; num1 = 8'd5; num2 = 8'd5; out_sel = OP_ADD;
    #1 chk("next_state_off", int'(nextState), int'(S_IDLE));
    repeat (2) next_cycle();

    run_req(IN_LOAD, 87, 26, OP_ADD);
    chk("add_87_26", int'(out), 113);
    chk("add_87_26_carry", int'(carry), 0);

    run_req(IN_LOAD, 2, 4, OP_MUL);
    chk("mul_2_4", int'(out), 8);
    chk("mul_2_4_ovf", int'(ovf), 0);
    run_req(IN_LOAD, 200, 2, OP_MUL);
    chk("mul_200_2", int'(out), 144);
    chk("mul_200_2_ovf", int'(ovf), 1);

    run_req(IN_LOAD, 2, 4, OP_ADD);
    chk("chain_load", int'(out), 6);
    run_req(IN_PERSIST, 0, 4, OP_ADD);
    chk("chain_persist_add", int'(out), 10);
    run_req(IN_PERSIST, 0, 10, OP_SUB);
    chk("chain_persist_sub", int'(out), 0);
    chk("chain_zero", int'(zero), 1);

    run_req(IN_LOAD, 2, 4, OP_SUB);
    chk("sub_2_4", int'(out), 254);
    chk("sub_2_4_borrow", int'(carry), 1);
    run_req(IN_LOAD, 3, 9, OP_SHL);
    chk("shl_3_9", int'(out), 6);

    run_req(IN_LOAD, 50, 60, 7'b0000011);
    chk("err_two_hot_out", int'(out), 6);
    run_req(IN_LOAD, 50, 60, 7'd0);
    chk("err_zero_out", int'(out), 6);

    run_req(IN_LOAD, 200, 100, OP_ADD);
    chk("add_wrap", int'(out), 44);
    chk("add_wrap_carry", int'(carry), 1);
    run_req(IN_LOAD, 240, 60, OP_AND);
    chk("and", int'(out), 48);
    run_req(IN_LOAD, 160, 5, OP_OR);
    chk("or", int'(out), 165);
    run_req(IN_LOAD, 255, 15, OP_XOR);
    chk("xor", int'(out), 240);

    // Non-one-hot in_sel with enable high: nothing happens.
    on = 1'b1; in_sel = 3'b110; num1 = 8'd9; num2 = 8'd9; out_sel = OP_ADD;
    repeat (2) next_cycle();
    on = 1'b0;

    on = 1'b1; in_sel = IN_CLEAR; out_sel = 7'd0;
    next_cycle();
    m_out = '0; m_carry = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    on = 1'b0;
    chk("clear_out", int'(out), 0);

    run_req(IN_LOAD, 16, 16, OP_MUL);
    chk("mul_16_16", int'(out), 0);
    chk("mul_16_16_ovf", int'(ovf), 1);

    // Abort mid-MUL by dropping enable.
    run_req(IN_LOAD, 5, 6, OP_ADD);
    start_mul(3, 3, 3);
    on = 1'b0;
    next_cycle();
    exp_state = S_IDLE; exp_busy = 1'b0;
    chk("abort_out_kept", int'(out), 11);
    next_cycle();

    // Asynchronous reset mid-MUL.
    start_mul(200, 2, 3);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_out",   int'(out),       0);
    chk("rst_async_state", int'(currState), int'(S_IDLE));
    chk("rst_async_busy",  int'(busy),      0);
    exp_state = S_IDLE; exp_busy = 1'b0;
    m_out = '0; m_carry = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    on = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    run_req(IN_LOAD, 1, 1, OP_ADD);
    chk("post_reset_add", int'(out), 2);

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port on  input  1  enable; requests are accepted only while 1.
REQ-005 SHALL have port in_sel  input  3  one-hot operand source: 100 persist (A<=out, B<=num2), 010 load (A<=num1, B<=num2), 001 clear.
REQ-006 SHALL have port num1  input  WIDTH  operand A source.
REQ-007 SHALL have port num2  input  WIDTH  operand B source.
REQ-008 SHALL have port out_sel  input  7  one-hot op: bit6 ADD, bit5 SUB, bit4 AND, bit3 OR, bit2 XOR, bit1 SHL, bit0 MUL.
REQ-009 SHALL have port out  output  WIDTH  registered result.
REQ-010 SHALL have port carry  output  1  ADD carry-out / SUB borrow (A<B); 0 for other ops.
REQ-011 SHALL have port zero  output  1  1 when newly written out == 0.
REQ-012 SHALL have port ovf  output  1  MUL only: 1 when product bits [2*WIDTH-1:WIDTH] nonzero.
REQ-013 SHALL have port busy  output  1  1 while state is EXEC.
REQ-014 SHALL have port done  output  1  1 for exactly the DONE cycle.
REQ-015 SHALL have port err  output  1  1 for exactly the ERR cycle.
REQ-016 SHALL have port currState  output  2  registered state.
REQ-017 SHALL have port nextState  output  2  combinational next state.

Function
REQ-018 SHALL encode states IDLE=00, EXEC=01, DONE=10, ERR=11.
REQ-019 IDLE SHALL go to EXEC when on=1, in_sel is 100 or 010 and out_sel is one-hot; at that edge A, B and op SHALL be captured.
REQ-020 IDLE with on=1, valid in_sel, out_sel not one-hot (incl. 0) SHALL go to ERR; A, B, out, flags unchanged.
REQ-021 IDLE with on=1 and in_sel=001 SHALL clear A, B, out, carry, zero, ovf to 0 and remain IDLE.
REQ-022 IDLE with on=0 or in_sel not one-hot SHALL remain IDLE with no register change.
REQ-023 ADD/SUB/AND/OR/XOR/SHL SHALL spend one cycle in EXEC; out and flags written at the edge leaving EXEC.
REQ-024 MUL SHALL be shift-add, WIDTH cycles in EXEC; out = low WIDTH bits of A*B, written at the edge leaving EXEC.
REQ-025 SHL SHALL shift A left by B modulo WIDTH, zero-filling.
REQ-026 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-027 DONE and ERR SHALL each last one cycle, then IDLE; requests presented during EXEC/DONE/ERR SHALL be ignored.
REQ-028 on=0 during EXEC SHALL abort to IDLE at the next edge; out and flags keep pre-request values, no done pulse.
REQ-029 Persist SHALL use out as registered at the capture edge, so back-to-back persist requests chain results.
REQ-030 Latency: request sampled at edge n -> out valid and done=1 after edge n+1 (non-MUL) or n+WIDTH (MUL).

Reset
REQ-031 rst=0 SHALL immediately, without clk, force state IDLE and A, B, out, carry, zero, ovf, done, err, busy to 0.
REQ-032 rst=0 mid-MUL SHALL discard the partial product; after rst=1 the first accepted request starts from IDLE.

Verification
REQ-033 WIDTH=8, load, ADD, num1=87, num2=26 -> out=113, carry=0, zero=0; currState 00->01->10->00; done one cycle.
REQ-034 load, MUL, 2*4 -> out=8 after 8 EXEC cycles, ovf=0; load, MUL, 200*2 -> out=144, ovf=1.
REQ-035 load ADD 2+4 -> out=6; then persist ADD num2=4 -> out=10; then persist SUB num2=10 -> out=0, zero=1.
REQ-036 load SUB 2-4 -> out=254, carry=1; load SHL 3, num2=9 -> out=6.
REQ-037 out_sel=0000011 -> currState 11 for one cycle, err=1, out unchanged; out_sel=0 likewise.
REQ-038 rst low mid-MUL -> IDLE, out=0 without clock edge; on=0 mid-MUL -> IDLE, out keeps previous value, done never asserted.
